// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding one UART transmitter; parity bit enabled by UART_TX_ARB_PARITY_EN
module uart_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           frame_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_BAUD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_ARB_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_data;
    logic [IW-1:0]        r_last, r_grant, w_win;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit, w_bit_nxt;
    logic                 r_tx, w_tx_nxt, w_any, w_load, w_baud_last;
    int                   w_j;

    assign w_any       = |req_valid && !rst;
    assign w_load      = (r_state == IDLE) && w_any;
    assign w_baud_last = r_baud == LAST_BAUD;
    assign req_ready   = w_load ? {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win : '0;
    assign tx          = r_tx;
    assign busy        = r_state != IDLE;
    assign grant_id    = r_grant;
    assign frame_done  = (r_state == STOP) && w_baud_last;

    // Round-robin pick: the lowest rotation distance from last_grant+1 wins
    always_comb begin
        w_win = r_last;
        w_j   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_j = (int'(r_last) + k) % NUM_REQ;
            if (req_valid[IW'(w_j)]) w_win = IW'(w_j);
        end
    end

    // Next state and bit index; the bit index restarts whenever the state changes
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = START;
            START:   if (w_baud_last) w_state_nxt = DATA;
            DATA:    if (w_baud_last) begin
`ifdef UART_TX_ARB_PARITY_EN
                         if (r_bit == LAST_BIT) w_state_nxt = PARITY;
`else
                         if (r_bit == LAST_BIT) w_state_nxt = STOP;
`endif
                         else w_bit_nxt = r_bit + 1'b1;
                     end
`ifdef UART_TX_ARB_PARITY_EN
            PARITY:  if (w_baud_last) w_state_nxt = STOP;
`endif
            STOP:    if (w_baud_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt != r_state) w_bit_nxt = '0;
    end

    // Line level for the upcoming cycle, so the registered tx lines up with the state
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = r_data[w_bit_nxt];
`ifdef UART_TX_ARB_PARITY_EN
            PARITY:  w_tx_nxt = ^r_data;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    // Counters, tx line and the grant/data latch taken on the handshake edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_grant <= '0;
            r_last  <= IW'(NUM_REQ - 1);
        end else begin
            r_tx   <= w_tx_nxt;
            r_bit  <= w_bit_nxt;
            r_baud <= (r_state == IDLE || w_baud_last) ? '0 : r_baud + 1'b1;
            if (w_load) begin
                r_data  <= req_data[w_win*DATA_BITS +: DATA_BITS];
                r_grant <= w_win;
                r_last  <= w_win;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb (either UART_TX_ARB_PARITY_EN setting)
module tb_uart_tx_arb;
    localparam int N   = 4;
    localparam int CPB = 16;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    typedef struct {int id; logic [7:0] d;} exp_t;

    logic        clk = 0, rst = 1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx, busy, frame_done;
    logic [1:0]  grant_id;

    exp_t        sb[$];
    exp_t        mon_e;
    int          obs_g[$], gaps[$];
    int          checks = 0, failures = 0;
    int          m_cnt = 0, m_last = N - 1, m_gid = 0, m_w = 0, hs = 0, cyc = 0;
    int          mon_pos = 0, last_fd = -1000;
    bit          mon_act = 0, chk_en = 0, rand_data = 1;
    logic [15:0] mon_bits = '0;
    logic [3:0]  er;
    int          exp26[5] = '{0, 1, 2, 3, 0};

    uart_tx_arb #(.NUM_REQ(N), .DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int k = 1; k <= N; k++) if (v[2'((last + k) % N)]) return (last + k) % N;
        return 0;
    endfunction

    // Reference model: a granted frame keeps the line busy for FRAME cycles, then one idle cycle may hand over
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_cnt = 0; m_last = N - 1; m_gid = 0; sb.delete();
        end else if (m_cnt > 0) m_cnt--;
        else if (|req_valid) begin
            m_w = rr_pick(m_last, req_valid);
            sb.push_back('{m_w, req_data[m_w*8 +: 8]});
            m_last = m_w; m_gid = m_w; m_cnt = FRAME; hs++;
        end
    end

    // Per-cycle control outputs against the model
    always @(negedge clk) if (chk_en) begin
        er = (m_cnt == 0 && !rst && |req_valid) ? 4'(1 << rr_pick(m_last, req_valid)) : 4'b0;
        check("req_ready", req_ready, er);
        check("busy", busy, m_cnt > 0);
        check("frame_done", frame_done, m_cnt == 1);
        check("grant_id", grant_id, m_gid);
        if (m_cnt == 0) check("tx_idle", tx, 1);
    end

    // Monitor: deserialise tx, pop the scoreboard on each frame_done
    always @(negedge clk) begin
        if (rst) mon_act = 0;
        else if (chk_en) begin
            if (!mon_act && tx == 1'b0) begin
                mon_act = 1; mon_pos = 0; gaps.push_back(cyc - last_fd);
            end
            if (!mon_act && frame_done) check("frame_start_seen", mon_act, 1);
            if (mon_act) begin
                if (mon_pos % CPB == CPB / 2) mon_bits[mon_pos / CPB] = tx;
                if (frame_done) begin
                    check("frame_len", mon_pos, FRAME - 1);
                    obs_g.push_back(grant_id);
                    last_fd = cyc;
                    check("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("start_bit", mon_bits[0], 0);
                        check("data", mon_bits[8:1], mon_e.d);
`ifdef UART_TX_ARB_PARITY_EN
                        check("parity", mon_bits[9], ^mon_e.d);
`endif
                        check("stop_bit", mon_bits[NB-1], 1);
                        check("frame_owner", grant_id, mon_e.id);
                    end
                    mon_act = 0;
                end else if (mon_pos >= FRAME) begin
                    check("frame_done_seen", frame_done, 1);
                    mon_act = 0;
                end
                mon_pos++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_data) req_data = $urandom;
    endtask

    task automatic run_frames(input logic [3:0] v, input int n);
        int target, t;
        target = hs + n;
        t = 0;
        req_valid = v;
        while (hs < target && t < n * (FRAME + 8) + 20) begin tick(); t++; end
        req_valid = '0;
        t = 0;
        while (m_cnt > 0 && t < FRAME + 8) begin tick(); t++; end
        tick();
    endtask

    initial begin
        tick();
        chk_en = 1;
        tick(); tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 0;
        rand_data = 0;
        req_data = 32'h0000_A500;
        obs_g.delete();
        run_frames(4'b0010, 1);
        check("single_count", obs_g.size(), 1);
        if (obs_g.size() > 0) check("single_grant", obs_g[0], 1);
        req_data = 32'h0000_0001;
        run_frames(4'b0001, 1);
        rand_data = 1;
        rst = 1; tick(); tick(); rst = 0;
        obs_g.delete();
        run_frames(4'b1111, 5);
        check("rr_count", obs_g.size(), 5);
        for (int i = 0; i < 5 && i < obs_g.size(); i++) check("rr_order", obs_g[i], exp26[i]);
        run_frames(4'b0100, 1);
        obs_g.delete();
        run_frames(4'b0101, 2);
        check("skip_count", obs_g.size(), 2);
        if (obs_g.size() == 2) begin
            check("skip_first", obs_g[0], 0);
            check("skip_second", obs_g[1], 2);
        end
        obs_g.delete();
        gaps.delete();
        run_frames(4'b1000, 3);
        check("b2b_count", gaps.size(), 3);
        if (gaps.size() == 3) begin
            check("b2b_gap1", gaps[1], 2);
            check("b2b_gap2", gaps[2], 2);
        end
        req_valid = 4'b1111;
        for (int t = hs + 1, b = 0; hs < t && b < 50; b++) tick();
        repeat (69) tick();
        rst = 1;
        tick();
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 0);
        rst = 0;
        obs_g.delete();
        run_frames(4'b1111, 1);
        check("midrst_count", obs_g.size(), 1);
        if (obs_g.size() > 0) check("midrst_first", obs_g[0], 0);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) req_valid = 4'($urandom_range(0, 15));
            tick();
        end
        req_valid = '0;
        for (int t = 0; m_cnt > 0 && t < FRAME + 8; t++) tick();
        tick();
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing the tx line (legal values 2..8).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clk cycles per UART bit (legal values 2 or more).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on the posedge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port req_valid, input, NUM_REQ bits: bit i high means requester i holds a byte to send.
REQ-007 Port req_data, input, NUM_REQ*DATA_BITS bits: requester i's byte is at [i*DATA_BITS +: DATA_BITS].
REQ-008 Port req_ready, output, NUM_REQ bits: one-hot grant; the handshake completes on the edge where valid[i] and ready[i] are both high.
REQ-009 Port tx, output, 1 bit: serial UART line, registered, idle high.
REQ-010 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 Port grant_id, output, $clog2(NUM_REQ) bits: index of the requester that owns the frame in progress or the last frame.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse on the last clk of the stop bit.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-014 In IDLE, if any req_valid bit is high, the block SHALL combinationally assert req_ready for exactly one winner.
- The winner is chosen round-robin, searching from (last_grant+1) mod NUM_REQ upward.
- req_ready SHALL be all-zero in every state other than IDLE, and in IDLE when no req_valid bit is high.
REQ-015 On the handshake edge the block SHALL:
- latch the winner's byte;
- set grant_id and last_grant to the winner's index;
- move to START.
REQ-016 Bit timing SHALL be as follows:
- Each of START, DATA, PARITY and STOP SHALL last CLKS_PER_BIT cycles per bit, timed by a baud counter running 0..CLKS_PER_BIT-1.
- START drives tx=0.
- DATA sends DATA_BITS bits LSB first.
- PARITY drives the XOR of the latched data bits (even parity).
- STOP drives tx=1 for one bit.
REQ-017 frame_done SHALL pulse on the final cycle of STOP, after which the FSM SHALL enter IDLE.
- The earliest next handshake is in that IDLE cycle.
- The earliest next start bit is therefore 2 cycles after the frame_done cycle.
REQ-018 Changes on req_data or req_valid after the handshake SHALL NOT affect the frame in progress.
REQ-019 A requester that drops req_valid before it is granted SHALL be skipped without penalty.
REQ-020 A single requester holding req_valid continuously SHALL be granted again only after every other requester that is valid when it is skipped over has been granted.
REQ-021 The bit counter and baud counter SHALL wrap to 0 on every state transition.

Reset
REQ-022 While rst is high at a posedge, the block SHALL on the next cycle set:
- FSM to IDLE, tx=1, busy=0, req_ready=0;
- frame_done=0, grant_id=0;
- all counters to 0;
- last_grant to NUM_REQ-1, so that requester 0 has first priority.
REQ-023 Reset asserted mid-frame SHALL abandon the frame: the frame is not resumed and the abandoned requester gets no handshake.

Configuration
REQ-024 Macro UART_TX_ARB_PARITY_EN SHALL control the parity bit.
- When defined, the PARITY state is present and the frame is 1+DATA_BITS+1+1 bits.
- When undefined, the PARITY state and its logic are absent, DATA goes directly to STOP, and the frame is 1+DATA_BITS+1 bits.

Verification
(All scenarios use NUM_REQ=4, DATA_BITS=8, CLKS_PER_BIT=16.)
REQ-025 Parity enabled, only req_valid[1] high with byte 0xA5 -> the bench SHALL check:
- req_ready=4'b0010 for one cycle and grant_id=1;
- tx for 16 cycles each: 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1;
- frame_done exactly on cycle 176 counted from the first tx-low cycle.
REQ-026 req_valid=4'b1111 held for five frames -> grants SHALL be 0,1,2,3,0.
REQ-027 Last grant was 2 and req_valid=4'b0101 -> the next grant SHALL be 0, then 2.
REQ-028 rst asserted during the fourth DATA bit -> the bench SHALL check:
- next cycle tx=1, busy=0, req_ready=0;
- after release with req_valid=4'b1111, the first grant is 0.
REQ-029 UART_TX_ARB_PARITY_EN undefined, byte 0x01 -> frame SHALL be 160 cycles with tx = 0,1,0,0,0,0,0,0,0,1 per bit, and no parity bit.
REQ-030 Requester 3 held valid back-to-back -> tx SHALL be high for exactly one extra cycle after each stop bit.
- The next start bit SHALL begin 2 cycles after frame_done.
